// File: rtl/nios_qsys_multi_timer_pkg.sv
// Shared register map and bit positions for the multi-channel interval timer.
package nios_qsys_mtimer_pkg;

    typedef enum logic [1:0] {
        REG_STATUS  = 2'd0,
        REG_CONTROL = 2'd1,
        REG_PERIOD  = 2'd2,
        REG_SNAP    = 2'd3
    } reg_e;

    localparam int unsigned NUM_REGS   = 4;

    localparam int unsigned CTRL_ITO   = 0;
    localparam int unsigned CTRL_CONT  = 1;
    localparam int unsigned CTRL_START = 2;
    localparam int unsigned CTRL_STOP  = 3;
    localparam int unsigned PRESC_LSB  = 8;

    localparam int unsigned STAT_TO    = 0;
    localparam int unsigned STAT_RUN   = 1;

endpackage

// File: rtl/nios_qsys_multi_timer_if.sv
// Avalon-MM slave bus of the multi-channel timer, plus its interrupt line.
interface nios_qsys_multi_timer_if #(
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/nios_qsys_multi_timer_channel.sv
// One timer channel: prescaler, down-counter, period, control, TO/RUN flags and snapshot.
module nios_qsys_timer_channel
    import nios_qsys_mtimer_pkg::*;
#(
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PRESC_W      = 8,
    parameter int unsigned RESET_PERIOD = 49999
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REGS-1:0]        i_wr,
    input  logic [31:0]                i_wdata,
    output logic [NUM_REGS-1:0][31:0]  o_rd,
    output logic                       o_irq
);

    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_snap;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] r_presc_cnt;
    logic               r_ito;
    logic               r_cont;
    logic               r_to;
    logic               r_run;

    logic w_tick;
    logic w_terminal;
    logic w_unused_wdata;

    assign w_tick         = r_run && (r_presc_cnt == r_presc);
    assign w_terminal     = w_tick && (r_cnt == '0);
    assign w_unused_wdata = ^i_wdata;

    // Later assignments win: STATUS write beats TO-set, PERIOD write beats tick and START.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= CNT_W'(RESET_PERIOD);
            r_period    <= CNT_W'(RESET_PERIOD);
            r_snap      <= '0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_ito       <= 1'b0;
            r_cont      <= 1'b0;
            r_to        <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            if (!r_run || w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end

            if (w_terminal) begin
                r_cnt <= r_period;
                r_to  <= 1'b1;
                if (!r_cont) begin
                    r_run <= 1'b0;
                end
            end else if (w_tick) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end

            if (i_wr[REG_STATUS]) begin
                r_to <= 1'b0;
            end

            if (i_wr[REG_CONTROL]) begin
                r_ito   <= i_wdata[CTRL_ITO];
                r_cont  <= i_wdata[CTRL_CONT];
                r_presc <= i_wdata[PRESC_LSB +: PRESC_W];
                if (i_wdata[CTRL_START]) begin
                    r_run <= 1'b1;
                end else if (i_wdata[CTRL_STOP]) begin
                    r_run <= 1'b0;
                end
            end

            if (i_wr[REG_PERIOD]) begin
                r_period    <= i_wdata[CNT_W-1:0];
                r_cnt       <= i_wdata[CNT_W-1:0];
                r_presc_cnt <= '0;
                r_run       <= 1'b0;
            end

            if (i_wr[REG_SNAP]) begin
                r_snap <= r_cnt;
            end
        end
    end

    always_comb begin
        o_rd                                 = '0;
        o_rd[REG_STATUS][STAT_TO]            = r_to;
        o_rd[REG_STATUS][STAT_RUN]           = r_run;
        o_rd[REG_CONTROL][CTRL_ITO]          = r_ito;
        o_rd[REG_CONTROL][CTRL_CONT]         = r_cont;
        o_rd[REG_CONTROL][PRESC_LSB +: PRESC_W] = r_presc;
        o_rd[REG_PERIOD]                     = 32'(r_period);
        o_rd[REG_SNAP]                       = 32'(r_snap);
    end

    assign o_irq = r_to & r_ito;

endmodule

// File: rtl/nios_qsys_multi_timer.sv
// Multi-channel interval timer top: address decode, channel array, registered read mux, irq OR.
module nios_qsys_multi_timer
    import nios_qsys_mtimer_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PRESC_W      = 8,
    parameter int unsigned RESET_PERIOD = 49999
) (
    input  logic                     clk,
    input  logic                     reset_n,
    nios_qsys_multi_timer_if.slave   bus
);

    logic [31:0]                             w_addr;
    logic [31:0]                             w_ch_idx;
    logic [1:0]                              w_reg;
    logic                                    w_wr_en;
    logic [NUM_CH-1:0][NUM_REGS-1:0]         w_wr;
    logic [NUM_CH-1:0][NUM_REGS-1:0][31:0]   w_rd;
    logic [NUM_CH-1:0]                       w_irq_ch;
    logic [31:0]                             w_rdata;
    logic [31:0]                             r_readdata;

    // Channel index is the address above the two register bits; out-of-range indices match no channel.
    assign w_addr   = 32'(bus.address);
    assign w_ch_idx = w_addr >> 2;
    assign w_reg    = w_addr[1:0];
    assign w_wr_en  = bus.chipselect & ~bus.write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_wr[g] = (w_wr_en && (w_ch_idx == 32'(g))) ? (NUM_REGS'(1) << w_reg) : '0;

        nios_qsys_timer_channel #(
            .CNT_W        (CNT_W),
            .PRESC_W      (PRESC_W),
            .RESET_PERIOD (RESET_PERIOD)
        ) u_ch (
            .clk     (clk),
            .rst_n   (reset_n),
            .i_wr    (w_wr[g]),
            .i_wdata (bus.writedata),
            .o_rd    (w_rd[g]),
            .o_irq   (w_irq_ch[g])
        );
    end

    always_comb begin
        w_rdata = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_ch_idx == i) begin
                w_rdata = w_rd[i][w_reg];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rdata;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = |w_irq_ch;

endmodule

// File: tb/tb_nios_qsys_multi_timer.sv
// Bench for nios_qsys_multi_timer: cycle model of the register rules plus directed literal checks.
module tb_nios_qsys_multi_timer;

    localparam int NCH = 4;

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    nios_qsys_multi_timer_if #(.ADDR_W(4)) bus  ();
    nios_qsys_multi_timer_if #(.ADDR_W(4)) bus2 ();

    nios_qsys_multi_timer #(
        .NUM_CH(4), .CNT_W(32), .PRESC_W(8), .RESET_PERIOD(49999)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    // Narrow build with a spare channel index (3) that must decode to nothing.
    nios_qsys_multi_timer #(
        .NUM_CH(3), .CNT_W(16), .PRESC_W(4), .RESET_PERIOD(1000)
    ) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(bus2)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of the main DUT ----------------
    logic [31:0] m_cnt   [NCH];
    logic [31:0] m_per   [NCH];
    logic [31:0] m_snap  [NCH];
    logic [7:0]  m_presc [NCH];
    logic [7:0]  m_pcnt  [NCH];
    logic        m_ito   [NCH];
    logic        m_cont  [NCH];
    logic        m_to    [NCH];
    logic        m_run   [NCH];
    logic [31:0] m_rd;

    function automatic logic [31:0] model_read(input int unsigned ch, input int unsigned rg);
        if (ch >= NCH) return 32'd0;
        case (rg)
            0:       return {30'd0, m_run[ch], m_to[ch]};
            1:       return {16'd0, m_presc[ch], 6'd0, m_cont[ch], m_ito[ch]};
            2:       return m_per[ch];
            default: return m_snap[ch];
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin : p_model
        logic        wr;
        logic        tick;
        int unsigned ch;
        int unsigned rg;
        logic [31:0] d;
        logic [31:0] old_cnt;
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_cnt[c] = 49999; m_per[c] = 49999; m_snap[c] = 0;
                m_presc[c] = 0; m_pcnt[c] = 0;
                m_ito[c] = 0; m_cont[c] = 0; m_to[c] = 0; m_run[c] = 0;
            end
            m_rd = 0;
        end else begin
            wr = bus.chipselect && !bus.write_n;
            ch = 32'(bus.address) >> 2;
            rg = 32'(bus.address) & 3;
            d  = bus.writedata;
            m_rd = model_read(ch, rg);
            for (int c = 0; c < NCH; c++) begin
                old_cnt = m_cnt[c];
                tick = m_run[c] && (m_pcnt[c] == m_presc[c]);
                if (tick) begin
                    m_pcnt[c] = 0;
                    if (m_cnt[c] == 0) begin
                        m_cnt[c] = m_per[c];
                        m_to[c]  = 1;
                        if (!m_cont[c]) m_run[c] = 0;
                    end else begin
                        m_cnt[c] = m_cnt[c] - 1;
                    end
                end else begin
                    m_pcnt[c] = m_run[c] ? m_pcnt[c] + 8'd1 : 8'd0;
                end
                if (wr && ch == c) begin
                    case (rg)
                        0: m_to[c] = 0;
                        1: begin
                            m_ito[c] = d[0]; m_cont[c] = d[1]; m_presc[c] = d[15:8];
                            if (d[2]) m_run[c] = 1;
                            else if (d[3]) m_run[c] = 0;
                        end
                        2: begin
                            m_per[c] = d; m_cnt[c] = d; m_pcnt[c] = 0; m_run[c] = 0;
                        end
                        default: m_snap[c] = old_cnt;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin : p_compare
        logic irq_exp;
        if (reset_n === 1'b1) begin
            irq_exp = 1'b0;
            for (int c = 0; c < NCH; c++) irq_exp = irq_exp | (m_to[c] & m_ito[c]);
            check("model readdata", bus.readdata, m_rd);
            check("model irq", 32'(bus.irq), 32'(irq_exp));
        end
    end

    // ---------------- bus tasks: entered and left 1ns after a rising edge ----------------
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.chipselect = 1'b1; bus.write_n = 1'b0;
        @(posedge clk); #1;
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        bus.address = a; bus.chipselect = 1'b1; bus.write_n = 1'b1;
        @(posedge clk); #1;
        d = bus.readdata; bus.chipselect = 1'b0;
    endtask

    task automatic wr2(input logic [3:0] a, input logic [31:0] d);
        bus2.address = a; bus2.writedata = d; bus2.chipselect = 1'b1; bus2.write_n = 1'b0;
        @(posedge clk); #1;
        bus2.chipselect = 1'b0; bus2.write_n = 1'b1;
    endtask

    task automatic rd2(input logic [3:0] a, output logic [31:0] d);
        bus2.address = a; bus2.chipselect = 1'b1; bus2.write_n = 1'b1;
        @(posedge clk); #1;
        d = bus2.readdata; bus2.chipselect = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        logic [31:0] d;
        int          k;
        reset_n = 1'b0;
        bus.address = '0;  bus.chipselect = 1'b0;  bus.write_n = 1'b1;  bus.writedata = '0;
        bus2.address = '0; bus2.chipselect = 1'b0; bus2.write_n = 1'b1; bus2.writedata = '0;

        #23;
        check("reset readdata", bus.readdata, 32'd0);
        check("reset irq", 32'(bus.irq), 32'd0);
        check("reset readdata16", bus2.readdata, 32'd0);
        #4 reset_n = 1'b1;
        @(posedge clk); #1;

        rd(4'd2, d); check("ch0 PERIOD after reset", d, 32'd49999);
        rd(4'd0, d); check("ch0 STATUS after reset", d, 32'd0);
        check("irq idle", 32'(bus.irq), 32'd0);

        // ch1 continuous, PERIOD=9, PRESC=0: timeout every 10 cycles
        wr(4'd6, 32'd9);
        wr(4'd5, 32'h7);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!bus.irq && k < 50);
        check("ch1 first timeout cycles", 32'(k), 32'd10);
        wr(4'd4, 32'd0);
        check("ch1 irq after STATUS clear", 32'(bus.irq), 32'd0);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!bus.irq && k < 50);
        check("ch1 cycles to next timeout", 32'(k), 32'd9);
        rd(4'd5, d); check("ch1 CONTROL readback", d, 32'h3);
        wr(4'd5, 32'h8);
        wr(4'd4, 32'd0);

        // ch2 one-shot, PERIOD=3, PRESC=4: TO set 20 edges after START, seen by the 21st read
        wr(4'd10, 32'd3);
        wr(4'd9, 32'h404);
        k = 0;
        do begin rd(4'd8, d); k++; end while (!d[0] && k < 100);
        check("ch2 one-shot read count", 32'(k), 32'd21);
        check("ch2 STATUS TO=1 RUN=0", d, 32'h1);
        wr(4'd11, 32'd0);
        rd(4'd11, d); check("ch2 counter holds period", d, 32'd3);

        // ch0 running, then PERIOD write forces reload and stop
        wr(4'd1, 32'h6);
        idle(5);
        wr(4'd2, 32'd100);
        rd(4'd0, d); check("ch0 RUN cleared by PERIOD write", d, 32'd0);
        wr(4'd3, 32'd0);
        rd(4'd3, d); check("ch0 SNAP after reload", d, 32'd100);
        rd(4'd2, d); check("ch0 PERIOD readback", d, 32'd100);

        // ch3: STATUS clear on the same edge as the terminal tick
        wr(4'd14, 32'd4);
        wr(4'd13, 32'h5);
        idle(4);
        wr(4'd12, 32'd0);
        check("ch3 irq clear wins", 32'(bus.irq), 32'd0);
        rd(4'd12, d); check("ch3 STATUS after coincident clear", d, 32'd0);
        wr(4'd13, 32'hC);
        rd(4'd12, d); check("ch3 START beats STOP", d, 32'h2);
        wr(4'd13, 32'h8);

        // asynchronous reset while ch1 is asserting irq
        wr(4'd5, 32'h7);
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!bus.irq && k < 40);
        check("ch1 irq before async reset", 32'(bus.irq), 32'd1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async reset irq", 32'(bus.irq), 32'd0);
        check("async reset readdata", bus.readdata, 32'd0);
        #10 reset_n = 1'b1;
        @(posedge clk); #1;
        rd(4'd6, d); check("ch1 PERIOD after async reset", d, 32'd49999);
        rd(4'd5, d); check("ch1 CONTROL after async reset", d, 32'd0);

        // 16-bit, 3-channel build
        wr2(4'd2, 32'h0001_FFFF);
        rd2(4'd2, d); check("w16 PERIOD truncated", d, 32'h0000_FFFF);
        wr2(4'd14, 32'd5);
        rd2(4'd14, d); check("w16 channel 3 reads 0", d, 32'd0);
        rd2(4'd2, d); check("w16 ch0 untouched by ch3 write", d, 32'h0000_FFFF);
        rd2(4'd6, d); check("w16 ch1 reset PERIOD", d, 32'd1000);
        wr2(4'd1, 32'h0000_FF03);
        rd2(4'd1, d); check("w16 CONTROL PRESC width", d, 32'h0000_0F03);
        check("w16 irq", 32'(bus2.irq), 32'd0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
